// File: rtl/fxp_mul_share_arbiter_pkg.sv
// Shared formats, multiplier latency and the in-flight tag type for the
// shared fixed-point multiplier arbiter.
package fxp_mul_share_arbiter_pkg;

  localparam int FXP_A_INT   = 3;
  localparam int FXP_A_FRAC  = 4;
  localparam int FXP_A_W     = FXP_A_INT + FXP_A_FRAC;
  localparam int FXP_B_INT   = 4;
  localparam int FXP_B_FRAC  = 3;
  localparam int FXP_B_W     = FXP_B_INT + FXP_B_FRAC;
  localparam int FXP_R_INT   = 5;
  localparam int FXP_R_FRAC  = 6;
  localparam int FXP_R_W     = FXP_R_INT + FXP_R_FRAC;

  localparam int FXP_MUL_LAT = 2;

  // Wide enough for the largest supported requester count (8).
  localparam int TAG_ID_W    = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int rr_succ(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fxp_mul_share_arbiter_rr_grant_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping modulo NREQ, yields a one-hot grant and its index.
module rr_grant_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [IDW-1:0]  ptr,
  input  logic [NREQ-1:0] req_valid,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

  // Two passes: upper segment [ptr, NREQ) first, then the wrapped [0, ptr).
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (enable) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_any && req_valid[i] && (i >= int'(ptr))) begin
          grant[i]  = 1'b1;
          grant_idx = IDW'(i);
          grant_any = 1'b1;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_any && req_valid[i] && (i < int'(ptr))) begin
          grant[i]  = 1'b1;
          grant_idx = IDW'(i);
          grant_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fxp_mul_share_arbiter.sv
// Shares one pipelined fixed-point multiplier among NREQ requesters with
// round-robin grants, an ID tag pipe and per-requester sticky overflow.
module fxp_mul_share_arbiter
  import fxp_mul_share_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int A_W     = FXP_A_W,
  parameter int B_W     = FXP_B_W,
  parameter int R_W     = FXP_R_W,
  parameter int MUL_LAT = FXP_MUL_LAT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*A_W-1:0] req_a,
  input  logic [NREQ*B_W-1:0] req_b,
  output logic [A_W-1:0]      mul_a,
  output logic [B_W-1:0]      mul_b,
  input  logic [R_W-1:0]      mul_result,
  input  logic                mul_ovf,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [R_W-1:0]      rsp_data,
  output logic                rsp_ovf,
  output logic [NREQ-1:0]     ovf_sticky,
  input  logic [NREQ-1:0]     ovf_clr,
  output logic                busy
);

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic [A_W-1:0]  a_sel;
  logic [B_W-1:0]  b_sel;
  logic [NREQ-1:0] ovf_set;
  tag_t            tag_q [MUL_LAT+1];
  tag_t            tag_last;

  // Grants are masked while reset is held so req_ready reads 0 asynchronously.
  rr_grant_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .ptr       (ptr),
    .req_valid (req_valid),
    .enable    (enable & reset),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*A_W +: A_W];
        b_sel = req_b[i*B_W +: B_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else if (grant_any) begin
      ptr   <= IDW'(rr_succ(int'(grant_idx), NREQ));
      mul_a <= a_sel;
      mul_b <= b_sel;
    end
  end

  // One stage per multiplier cycle plus the operand register stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s <= MUL_LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= '{valid: grant_any, id: TAG_ID_W'(grant_idx)};
      for (int s = 1; s <= MUL_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign tag_last  = tag_q[MUL_LAT];
  assign rsp_valid = tag_last.valid;
  assign rsp_id    = IDW'(tag_last.id);
  assign rsp_data  = rsp_valid ? mul_result : '0;
  assign rsp_ovf   = rsp_valid & mul_ovf;

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s <= MUL_LAT; s++) busy = busy | tag_q[s].valid;
  end

  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < NREQ; i++) begin
      ovf_set[i] = rsp_ovf && (rsp_id == IDW'(i));
    end
  end

  // Set is OR-ed after the clear so a coincident set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_sticky <= '0;
    end else begin
      ovf_sticky <= (ovf_sticky & ~ovf_clr) | ovf_set;
    end
  end

endmodule

// File: tb/tb_fxp_mul_share_arbiter.sv
// Vector table plus scoreboard bench for fxp_mul_share_arbiter with a
// two-stage saturating Q3.4 x Q4.3 -> Q5.6 multiplier model.
module tb_fxp_mul_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int A_W  = 7;
  localparam int B_W  = 7;
  localparam int R_W  = 11;
  localparam int LAT  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A_W-1:0] req_a;
  logic [NREQ*B_W-1:0] req_b;
  logic [A_W-1:0]      mul_a;
  logic [B_W-1:0]      mul_b;
  logic [R_W-1:0]      mul_result;
  logic                mul_ovf;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [R_W-1:0]      rsp_data;
  logic                rsp_ovf;
  logic [NREQ-1:0]     ovf_sticky;
  logic [NREQ-1:0]     ovf_clr;
  logic                busy;

  fxp_mul_share_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .mul_ovf    (mul_ovf),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ovf    (rsp_ovf),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // {ovf, data}: signed product >> 1, saturated to 11 bits.
  function automatic logic [11:0] mul_fn(input logic [6:0] a, input logic [6:0] b);
    logic signed [13:0] p;
    logic signed [12:0] s;
    p = 14'($signed(a) * $signed(b));
    s = p[13:1];
    if (s > 13'sd1023)       return {1'b1, 11'h3FF};
    else if (s < -13'sd1024) return {1'b1, 11'h400};
    else                     return {1'b0, s[10:0]};
  endfunction

  logic [11:0] mp1 = '0;
  logic [11:0] mp2 = '0;
  always @(posedge clk) begin
    mp1 <= mul_fn(mul_a, mul_b);
    mp2 <= mp1;
  end
  assign mul_result = mp2[10:0];
  assign mul_ovf    = mp2[11];

  logic [6:0] op_a [NREQ] = '{7'h10, 7'h18, 7'h3F, 7'h7F};
  logic [6:0] op_b [NREQ] = '{7'h08, 7'h14, 7'h3F, 7'h10};

  typedef struct {
    logic [1:0]  id;
    logic [10:0] data;
    logic        ovf;
    int          due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] valid;
    logic       en;
    logic [3:0] clr;
    logic [3:0] rdy;
  } vec_t;
  vec_t vecs[$];

  int         n_pass = 0;
  int         n_total = 0;
  int         cyc = 0;
  logic [3:0] exp_sticky = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic add(input logic [3:0] v, input logic en, input logic [3:0] clr, input logic [3:0] rdy);
    vec_t t;
    t.valid = v; t.en = en; t.clr = clr; t.rdy = rdy;
    vecs.push_back(t);
  endtask

  task automatic cycle(input logic [3:0] v, input logic en, input logic [3:0] clr, input logic [3:0] rdy);
    exp_t       e;
    exp_t       n;
    logic       got;
    logic [11:0] m;
    @(posedge clk); #1;
    req_valid = v;
    enable    = en;
    ovf_clr   = clr;
    @(negedge clk);
    cyc++;
    got = 1'b0;
    chk("busy", 32'(busy), 32'(sb.size() != 0));
    chk("ovf_sticky", 32'(ovf_sticky), 32'(exp_sticky));
    chk("req_ready", 32'(req_ready), 32'(rdy));
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        got = 1'b1;
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
        chk("rsp_latency", 32'(cyc), 32'(e.due));
      end
    end else begin
      chk("rsp_gate", {20'd0, rsp_ovf, rsp_data}, 32'd0);
      if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("missing_rsp", 32'(rsp_valid), 32'd1);
      end
    end
    exp_sticky = exp_sticky & ~clr;
    if (got && e.ovf) exp_sticky[e.id] = 1'b1;
    if (rdy != 0) begin
      n.id   = idx_of(rdy);
      m      = mul_fn(op_a[n.id], op_b[n.id]);
      n.data = m[10:0];
      n.ovf  = m[11];
      n.due  = cyc + LAT + 1;
      sb.push_back(n);
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*A_W +: A_W] = op_a[i];
      req_b[i*B_W +: B_W] = op_b[i];
    end
    reset     = 1'b0;
    enable    = 1'b1;
    req_valid = 4'b1111;
    ovf_clr   = '0;

    // single request, then steer ptr back to 0
    add(4'b0010, 1, 4'b0000, 4'b0010);
    repeat (3) add(4'b0000, 1, 4'b0000, 4'b0000);
    add(4'b1000, 1, 4'b0000, 4'b1000);
    // round robin, all valid
    for (int k = 0; k < 8; k++) add(4'b1111, 1, 4'b0000, 4'(1 << (k % 4)));
    repeat (4) add(4'b0000, 1, 4'b0000, 4'b0000);
    // fresh overflow on id 2 coinciding with clear, then clear alone
    add(4'b0100, 1, 4'b0000, 4'b0100);
    repeat (2) add(4'b0000, 1, 4'b0000, 4'b0000);
    add(4'b0000, 1, 4'b0100, 4'b0000);
    add(4'b0000, 1, 4'b0100, 4'b0000);
    add(4'b0000, 1, 4'b0000, 4'b0000);
    // enable drop after two accepts
    add(4'b1111, 1, 4'b0000, 4'b1000);
    add(4'b1111, 1, 4'b0000, 4'b0001);
    repeat (5) add(4'b1111, 0, 4'b0000, 4'b0000);

    #7;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_outputs", {18'd0, rsp_valid, rsp_id, rsp_data, rsp_ovf, busy}, 32'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    for (int v = 0; v < vecs.size(); v++) cycle(vecs[v].valid, vecs[v].en, vecs[v].clr, vecs[v].rdy);

    // reset one cycle after an accept (ptr is 1 here)
    cycle(4'b1111, 1, 4'b0000, 4'b0010);
    @(posedge clk); #1;
    req_valid = 4'b1111;
    enable    = 1'b1;
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_ready", 32'(req_ready), 32'b0100);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_outputs", {18'd0, rsp_valid, rsp_id, rsp_data, rsp_ovf, busy}, 32'd0);
    req_valid = '0;
    sb.delete();
    exp_sticky = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    cycle(4'b1111, 1, 4'b0000, 4'b0001);
    repeat (5) cycle(4'b0000, 1, 4'b0000, 4'b0000);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fxp_mul_share_arbiter.md
Name: fxp_mul_share_arbiter

Overview:
- Shares one pipelined fixed-point multiplier among NREQ requesters.
- Round-robin arbitration with a valid/ready handshake on each requester.
- Registers the granted operands onto the multiplier inputs and tracks every in-flight product with a requester-ID tag pipeline.
- Returns each result tagged with its ID, and keeps per-requester sticky overflow flags.

Parameters:
- NREQ, 4: number of requesters (2..8).
- IDW, 2: ID width; must satisfy 2**IDW >= NREQ.
- A_W, 7: operand-A width (Q3.4).
- B_W, 7: operand-B width (Q4.3).
- R_W, 11: result width (Q5.6).
- MUL_LAT, 2: cycles from a mul_a/mul_b change to mul_result/mul_ovf reflecting it.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = grants allowed; 0 = no new grants, in-flight work still completes.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester grant; at most one bit set.
- req_a  in  NREQ*A_W  flattened operand A; requester i at [i*A_W +: A_W].
- req_b  in  NREQ*B_W  flattened operand B; requester i at [i*B_W +: B_W].
- mul_a  out  A_W  registered operand to the multiplier.
- mul_b  out  B_W  registered operand to the multiplier.
- mul_result  in  R_W  multiplier product.
- mul_ovf  in  1  multiplier overflow flag.
- rsp_valid  out  1  result valid; single-cycle pulse per accepted request.
- rsp_id  out  IDW  requester index of the result.
- rsp_data  out  R_W  result; equals mul_result.
- rsp_ovf  out  1  overflow of this result.
- ovf_sticky  out  NREQ  per-requester sticky overflow.
- ovf_clr  in  NREQ  per-requester clear pulse for ovf_sticky.
- busy  out  1  any tag stage valid.

Behaviour:
- Reset (reset=0, async): clears pointer, mul_a, mul_b, all tag stages, ovf_sticky.
  - Outputs during reset: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_ovf=0, busy=0.
  - Reset mid-operation drops all in-flight results; no rsp_valid is emitted for them after release.
- Arbitration (combinational):
  - Search starts at pointer ptr and proceeds ptr, ptr+1, ... mod NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1, only when enable=1.
  - req_ready never asserts to a requester whose req_valid=0.
- Transfer: valid & ready at a rising edge.
  - mul_a and mul_b load that requester's operands.
  - Tag stage 0 loads {valid=1, id=i}.
  - ptr updates to (i+1) mod NREQ.
- No transfer: mul_a and mul_b hold their values; tag stage 0 loads valid=0; ptr unchanged.
- Tag pipeline: MUL_LAT+1 stages, shifting every cycle.
  - rsp_valid and rsp_id come from the last stage.
  - rsp_data = mul_result and rsp_ovf = mul_ovf, gated to 0 when rsp_valid=0.
- Latency: request accepted at edge k gives rsp_valid=1 in the cycle after edge k+MUL_LAT.
- Throughput: one accept per cycle; results return in accept order. Results have no backpressure; consumers must accept every pulse.
- Fairness: a requester holding valid while enable=1 is granted within NREQ cycles.
- Sticky overflow: rsp_valid & rsp_ovf sets ovf_sticky[rsp_id] at the edge.
  - ovf_clr[i] clears bit i.
  - Set and clear on the same bit in the same cycle: set wins.
- enable falling: no grant from that cycle on; busy stays high until the tag pipe drains.
- Operands held stable across non-accept cycles: the repeated products carry no valid tag and are never reported.
- Arithmetic: none inside the block; widths pass through unchanged.

Decomposition:
- Shared package holds:
  - Format defaults: A_W/B_W/R_W, plus integer/fraction splits 3/4, 4/3, 5/6.
  - MUL_LAT.
  - A tag struct/typedef {valid, id[IDW-1:0]}.
- One sub-module, rr_grant_picker: ptr, req_valid and enable in; one-hot grant and encoded index out; purely combinational.
- Tag pipe, ptr register and sticky flags stay in the top.

Test Plan:
- Single request: after reset, req_valid[1]=1, a=0x18 (1.5), b=0x14 (2.5); multiplier model returns 0x0F0.
  -> req_ready=4'b0010 for one cycle; rsp_valid in the cycle after edge k+2 with rsp_id=1, rsp_data=0x0F0, rsp_ovf=0.
- Round robin: all four valid continuously for 8 cycles.
  -> grant order 0,1,2,3,0,1,2,3; rsp_id sequence identical; one rsp_valid per cycle.
- Overflow and sticky: requester 2 sends a=0x3F, b=0x3F; model asserts mul_ovf.
  -> rsp_ovf=1 and ovf_sticky=4'b0100.
  -> ovf_clr[2] pulsed in the same cycle as a new overflow on id 2: bit stays 1.
  -> ovf_clr[2] pulsed alone: bit clears.
- Enable gating: enable drops after 2 accepts while req_valid=4'b1111.
  -> no further req_ready; both results still return; busy falls the cycle after the last rsp_valid.
- Reset mid-flight: reset asserted one cycle after an accept, released 3 cycles later.
  -> outputs 0 immediately (async); no rsp_valid after release; first grant after release goes to requester 0.
